tb_check_monitor: RTL and testbench

- Parametrised in-bench checker, instantiated inside testbench modules alongside the DUT. Single clock domain.
- Compares N expected/actual channels per clock under a bit mask and counts mismatches.
- Provides a cycle-count watchdog and a sticky all-ok/pass/fail verdict.
- Generalises the bench pass flag and timeout to multi-channel, clocked, synthesizable form usable on hardware.

---
 rtl/tb_check_pkg.sv | 25 ++
 rtl/tb_sat_counter.sv | 47 ++++
 rtl/tb_check_monitor.sv | 166 ++++++++++++++++
 tb/tb_tb_check_monitor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/tb_check_pkg.sv
// rtl/tb_check_pkg.sv - shared types and helpers for the in-bench check monitor
// Contents: verdict state encoding (IDLE/RUN/PASS/FAIL), STATE_W, and a
// popcount helper sized for the 16-channel maximum.
package tb_check_pkg;

    localparam int STATE_W = 2;
    localparam int POP_W   = 5;  // enough to hold a count of 0..16

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    function automatic logic [POP_W-1:0] popcount16(input logic [15:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/tb_sat_counter.sv
// rtl/tb_sat_counter.sv - clearable counter that adds a variable amount and saturates
// Ports:
//   clk, rst      clock, asynchronous active-high reset (count -> 0)
//   clr           synchronous clear, takes priority over inc
//   inc, amt      when inc is high, count += amt, clamped at all-ones
//   count         registered count value
module tb_sat_counter #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] count
);

    // One spare bit above the wider operand so the sum can never wrap before
    // it is compared against the saturation limit.
    localparam int SUM_W = ((WIDTH > AMT_W) ? WIDTH : AMT_W) + 1;
    localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'({WIDTH{1'b1}});

    logic [WIDTH-1:0] count_q, count_d;
    logic [SUM_W-1:0] sum;

    always_comb begin
        sum     = SUM_W'(count_q) + SUM_W'(amt);
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = (sum > MAX_SUM) ? '1 : sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tb_check_monitor.sv
// rtl/tb_check_monitor.sv - multi-channel masked compare checker with watchdog and sticky verdict
// Parameters: CHANNELS (1..16), WIDTH, TIMEOUT_CYCLES (0 = no watchdog), ERRCNT_WIDTH.
// Ports:
//   CLK, RST                       clock, asynchronous active-high reset
//   START, END_REQ                 begin/restart a run, request the verdict
//   CHK_VALID/EXPECT/ACTUAL/MASK   per-channel strobe and packed compare data
//   ALL_OK, ERR_COUNT, FAIL_CHAN   sticky health, saturating error total, per-channel flags
//   TIMED_OUT, DONE, STATE         watchdog fired, verdict ready, IDLE/RUN/PASS/FAIL
// Optional: define TB_CHECK_LOG_EN to print mismatches and the final verdict
// (simulation only; register behaviour is the same either way).
module tb_check_monitor
    import tb_check_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 250,
    parameter int ERRCNT_WIDTH   = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      START,
    input  logic                      END_REQ,
    input  logic [CHANNELS-1:0]       CHK_VALID,
    input  logic [CHANNELS*WIDTH-1:0] CHK_EXPECT,
    input  logic [CHANNELS*WIDTH-1:0] CHK_ACTUAL,
    input  logic [CHANNELS*WIDTH-1:0] CHK_MASK,
    output logic                      ALL_OK,
    output logic [ERRCNT_WIDTH-1:0]   ERR_COUNT,
    output logic [CHANNELS-1:0]       FAIL_CHAN,
    output logic                      TIMED_OUT,
    output logic                      DONE,
    output logic [STATE_W-1:0]        STATE
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);

    state_e                state_q, state_d;
    logic                  all_ok_q, all_ok_d;
    logic [CHANNELS-1:0]   fail_chan_q, fail_chan_d;
    logic                  timed_out_q, timed_out_d;
    logic                  done_q, done_d;

    logic                  in_run;
    logic                  entering_run;
    logic [CHANNELS-1:0]   mismatch;
    logic [POP_W-1:0]      mm_count;
    logic [WD_W-1:0]       wd_count;
    logic                  wd_expire;

    assign in_run       = (state_q == ST_RUN);
    // START is only honoured outside RUN; inside RUN it is ignored.
    assign entering_run = START && !in_run;

    always_comb begin
        mismatch = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mismatch[i] = in_run && CHK_VALID[i] &&
                (|((CHK_EXPECT[i*WIDTH +: WIDTH] ^ CHK_ACTUAL[i*WIDTH +: WIDTH])
                   & CHK_MASK[i*WIDTH +: WIDTH]));
        end
    end

    assign mm_count  = popcount16(16'(mismatch));
    assign wd_expire = WD_EN && (wd_count == WD_LAST);

    tb_sat_counter #(.WIDTH(ERRCNT_WIDTH), .AMT_W(POP_W)) u_err_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clr   (entering_run),
        .inc   (in_run),
        .amt   (mm_count),
        .count (ERR_COUNT)
    );

    tb_sat_counter #(.WIDTH(WD_W), .AMT_W(1)) u_watchdog (
        .clk   (CLK),
        .rst   (RST),
        .clr   (entering_run),
        .inc   (in_run),
        .amt   (1'b1),
        .count (wd_count)
    );

    always_comb begin
        state_d     = state_q;
        all_ok_d    = all_ok_q;
        fail_chan_d = fail_chan_q;
        timed_out_d = timed_out_q;
        case (state_q)
            ST_RUN: begin
                // Compares of the END_REQ / expiry cycle still count.
                fail_chan_d = fail_chan_q | mismatch;
                if (|mismatch) begin
                    all_ok_d = 1'b0;
                end
                // END_REQ outranks watchdog expiry in the same cycle.
                if (END_REQ) begin
                    state_d = (all_ok_q && !(|mismatch)) ? ST_PASS : ST_FAIL;
                end else if (wd_expire) begin
                    state_d     = ST_FAIL;
                    timed_out_d = 1'b1;
                    all_ok_d    = 1'b0;
                end
            end
            default: begin
                if (START) begin
                    state_d     = ST_RUN;
                    all_ok_d    = 1'b1;
                    fail_chan_d = '0;
                    timed_out_d = 1'b0;
                end
            end
        endcase
        done_d = (state_d == ST_PASS) || (state_d == ST_FAIL);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            all_ok_q    <= 1'b1;
            fail_chan_q <= '0;
            timed_out_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            all_ok_q    <= all_ok_d;
            fail_chan_q <= fail_chan_d;
            timed_out_q <= timed_out_d;
            done_q      <= done_d;
        end
    end

    assign ALL_OK    = all_ok_q;
    assign FAIL_CHAN = fail_chan_q;
    assign TIMED_OUT = timed_out_q;
    assign DONE      = done_q;
    assign STATE     = state_q;

`ifdef TB_CHECK_LOG_EN
    // Summary is printed on the cycle DONE first rises so it shows the final
    // registered totals, including any errors from the END_REQ cycle.
    logic log_done_q;
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            log_done_q <= 1'b0;
        end else begin
            log_done_q <= done_q;
            for (int i = 0; i < CHANNELS; i++) begin
                if (mismatch[i]) begin
                    $display("%0t tb_check_monitor: ch%0d mismatch exp=%h act=%h mask=%h",
                             $time, i, CHK_EXPECT[i*WIDTH +: WIDTH],
                             CHK_ACTUAL[i*WIDTH +: WIDTH], CHK_MASK[i*WIDTH +: WIDTH]);
                end
            end
            if (done_q && !log_done_q) begin
                $display("%0t tb_check_monitor: verdict=%s err_count=%0d fail_chan=%b timed_out=%0b",
                         $time, (state_q == ST_PASS) ? "pass" : "fail",
                         ERR_COUNT, fail_chan_q, timed_out_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_tb_check_monitor.sv
// tb/tb_tb_check_monitor.sv - self-checking bench for tb_check_monitor
module tb_tb_check_monitor;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int T  = 16;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    // Main instance (ERRCNT_WIDTH=8, TIMEOUT_CYCLES=16)
    logic            start, end_req;
    logic [CH-1:0]   valid;
    logic [CH*W-1:0] expv, actv, maskv;
    logic            all_ok, timed_out, done;
    logic [7:0]      err_count;
    logic [CH-1:0]   fail_chan;
    logic [1:0]      state;

    // Saturation instance (ERRCNT_WIDTH=2, watchdog disabled)
    logic            s_start, s_end;
    logic [CH-1:0]   s_valid;
    logic [CH*W-1:0] s_exp, s_act, s_mask;
    logic            s_all_ok, s_timed_out, s_done;
    logic [1:0]      s_err;
    logic [CH-1:0]   s_fail_chan;
    logic [1:0]      s_state;

    tb_check_monitor #(.CHANNELS(CH), .WIDTH(W), .TIMEOUT_CYCLES(T), .ERRCNT_WIDTH(8)) u_dut (
        .CLK(CLK), .RST(RST), .START(start), .END_REQ(end_req),
        .CHK_VALID(valid), .CHK_EXPECT(expv), .CHK_ACTUAL(actv), .CHK_MASK(maskv),
        .ALL_OK(all_ok), .ERR_COUNT(err_count), .FAIL_CHAN(fail_chan),
        .TIMED_OUT(timed_out), .DONE(done), .STATE(state)
    );

    tb_check_monitor #(.CHANNELS(CH), .WIDTH(W), .TIMEOUT_CYCLES(0), .ERRCNT_WIDTH(2)) u_sat (
        .CLK(CLK), .RST(RST), .START(s_start), .END_REQ(s_end),
        .CHK_VALID(s_valid), .CHK_EXPECT(s_exp), .CHK_ACTUAL(s_act), .CHK_MASK(s_mask),
        .ALL_OK(s_all_ok), .ERR_COUNT(s_err), .FAIL_CHAN(s_fail_chan),
        .TIMED_OUT(s_timed_out), .DONE(s_done), .STATE(s_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference model of the main instance: verdict, error total, flags and
    // run length kept as plain integers.
    int         m_state;
    bit         m_ok;
    int         m_err;
    logic [3:0] m_fc;
    bit         m_to;
    int         m_run_cycles;

    task automatic model_reset();
        m_state = 0; m_ok = 1'b1; m_err = 0; m_fc = '0; m_to = 1'b0; m_run_cycles = 0;
    endtask

    task automatic model_step();
        logic [3:0] mm;
        bit         ok_before;
        mm = '0;
        if (m_state == 1) begin
            for (int i = 0; i < CH; i++) begin
                mm[i] = valid[i] && (((expv[i*W +: W] ^ actv[i*W +: W]) & maskv[i*W +: W]) != 0);
            end
        end
        if (m_state != 1) begin
            if (start) begin
                m_state = 1; m_ok = 1'b1; m_err = 0; m_fc = '0; m_to = 1'b0; m_run_cycles = 0;
            end
        end else begin
            ok_before = m_ok;
            m_fc  = m_fc | mm;
            m_err = m_err + $countones(mm);
            if (m_err > 255) m_err = 255;
            if (mm != 0) m_ok = 1'b0;
            if (end_req) begin
                m_state = (ok_before && mm == 0) ? 2 : 3;
            end else if (m_run_cycles == T - 1) begin
                m_state = 3; m_to = 1'b1; m_ok = 1'b0;
            end
            m_run_cycles++;
        end
    endtask

    task automatic compare(input string tag);
        check({tag, ".state"},     32'(state),     32'(m_state));
        check({tag, ".all_ok"},    32'(all_ok),    32'(m_ok));
        check({tag, ".err_count"}, 32'(err_count), 32'(m_err));
        check({tag, ".fail_chan"}, 32'(fail_chan), 32'(m_fc));
        check({tag, ".timed_out"}, 32'(timed_out), 32'(m_to));
        check({tag, ".done"},      32'(done),      (m_state >= 2) ? 32'd1 : 32'd0);
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge CLK);
        #1;
        compare(tag);
    endtask

    task automatic idle_inputs();
        start = 1'b0; end_req = 1'b0; valid = '0; expv = '0; actv = '0; maskv = '0;
    endtask

    task automatic clean(input logic [CH-1:0] v);
        valid = v; expv = $urandom; actv = expv; maskv = '1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        RST = 1'b1;
        idle_inputs();
        s_start = 1'b0; s_end = 1'b0; s_valid = '0; s_exp = '0; s_act = '0; s_mask = '0;
        model_reset();
        #12;
        compare("reset");
        RST = 1'b0;

        // Clean pass
        start = 1'b1; cycle("start"); start = 1'b0;
        repeat (5) begin clean(4'hF); cycle("clean"); end
        idle_inputs(); end_req = 1'b1; cycle("end_pass"); end_req = 1'b0;
        check("pass.state", 32'(state), 32'd2);
        check("pass.done", 32'(done), 32'd1);
        check("pass.all_ok", 32'(all_ok), 32'd1);
        check("pass.err", 32'(err_count), 32'd0);

        // Masked vs unmasked mismatch on channel 2
        start = 1'b1; cycle("restart"); start = 1'b0;
        clean(4'h4);
        expv[23:16] = 8'hA5; actv[23:16] = 8'hA4; maskv[23:16] = 8'hFE;
        cycle("masked");
        check("masked.err", 32'(err_count), 32'd0);
        check("masked.all_ok", 32'(all_ok), 32'd1);
        maskv[23:16] = 8'hFF;
        cycle("unmasked");
        check("unmasked.fail_chan", 32'(fail_chan), 32'h4);
        check("unmasked.err", 32'(err_count), 32'd1);
        check("unmasked.all_ok", 32'(all_ok), 32'd0);
        idle_inputs(); end_req = 1'b1; cycle("end_fail"); end_req = 1'b0;
        check("end_fail.state", 32'(state), 32'd3);

        // Restart from FAIL
        start = 1'b1; cycle("restart_fail"); start = 1'b0;
        check("restart.state", 32'(state), 32'd1);
        check("restart.err", 32'(err_count), 32'd0);
        check("restart.fail_chan", 32'(fail_chan), 32'd0);
        clean(4'hF); end_req = 1'b1; cycle("restart_end"); end_req = 1'b0; idle_inputs();
        check("restart_end.state", 32'(state), 32'd2);

        // Watchdog expiry exactly T cycles after START
        start = 1'b1; cycle("wd_start"); start = 1'b0;
        repeat (T - 1) cycle("wd_wait");
        check("wd_before.state", 32'(state), 32'd1);
        cycle("wd_fire");
        check("wd_fire.state", 32'(state), 32'd3);
        check("wd_fire.timed_out", 32'(timed_out), 32'd1);

        // END_REQ on the expiry cycle wins
        start = 1'b1; cycle("wd2_start"); start = 1'b0;
        repeat (T - 1) cycle("wd2_wait");
        end_req = 1'b1; cycle("wd2_end"); end_req = 1'b0;
        check("wd_end.state", 32'(state), 32'd2);
        check("wd_end.timed_out", 32'(timed_out), 32'd0);

        // START together with END_REQ in RUN: END_REQ processed
        start = 1'b1; cycle("se_start");
        end_req = 1'b1; cycle("se_both"); start = 1'b0; end_req = 1'b0;
        check("start_end.state", 32'(state), 32'd2);

        // Asynchronous reset between edges mid-run
        start = 1'b1; cycle("ar_start"); start = 1'b0;
        clean(4'h1); actv[0] = ~actv[0]; cycle("ar_err"); idle_inputs();
        check("ar_err.err", 32'(err_count), 32'd1);
        #2 RST = 1'b1;
        #1;
        check("async_rst.all_ok", 32'(all_ok), 32'd1);
        check("async_rst.err", 32'(err_count), 32'd0);
        check("async_rst.state", 32'(state), 32'd0);
        check("async_rst.fail_chan", 32'(fail_chan), 32'd0);
        model_reset();
        #1 RST = 1'b0;

        // Saturation on a 2-bit counter, watchdog disabled
        s_start = 1'b1; cycle("sat_start"); s_start = 1'b0;
        check("sat_start.state", 32'(s_state), 32'd1);
        s_valid = 4'hF; s_exp = '0; s_act = '1; s_mask = '1;
        cycle("sat1");
        check("sat1.err", 32'(s_err), 32'd3);
        cycle("sat2");
        check("sat2.err", 32'(s_err), 32'd3);
        check("sat2.fail_chan", 32'(s_fail_chan), 32'hF);
        check("sat2.all_ok", 32'(s_all_ok), 32'd0);
        s_valid = '0;
        repeat (40) cycle("sat_nowd");
        check("nowd.state", 32'(s_state), 32'd1);
        check("nowd.timed_out", 32'(s_timed_out), 32'd0);
        check("nowd.done", 32'(s_done), 32'd0);
        s_end = 1'b1; cycle("sat_end"); s_end = 1'b0;
        check("sat_end.state", 32'(s_state), 32'd3);
        check("sat_end.done", 32'(s_done), 32'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            start   = ($urandom_range(0, 15) == 0);
            end_req = ($urandom_range(0, 11) == 0);
            valid   = 4'($urandom);
            expv    = $urandom;
            actv    = expv ^ (($urandom_range(0, 7) == 0) ? $urandom : 32'd0);
            maskv   = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
            cycle("rand");
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
